// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Definitions shared by the instruction fetch stage: the NOP word driven to
// decode when no instruction is available, the default reset PC, the fetch
// FSM state type and the prefetch queue entry layout.
// -----------------------------------------------------------------------------
package if_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    REQ  = 2'd1,  // request outstanding, its data will be kept
    DROP = 2'd2   // request outstanding, its data will be discarded
  } fetch_state_e;

  // One prefetch queue entry, 64 bits wide.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// if_prefetch_fifo
// DEPTH-entry FIFO holding fetched {pc, inst} pairs in program order.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push_i          write push_data_i at the tail (caller guarantees not full)
//   pop_i           drop the head entry (ignored when empty)
//   flush_i         empty the queue; overrides push and pop
//   push_data_i     entry to write
//   count_o         number of valid entries (0..DEPTH)
//   head_o          oldest entry; meaningful only when count_o != 0
// -----------------------------------------------------------------------------
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           push_data_i,
  output logic [$clog2(DEPTH):0] count_o,
  output fetch_entry_t           head_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic           do_pop;

  assign do_pop = pop_i && (count_q != '0);

  // NOTE: the storage array has no reset; validity is carried entirely by
  // count_q, so resetting the data would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage: owns the fetch PC, issues single-outstanding
// requests to a variable-latency instruction memory, buffers returned words
// in a prefetch queue and presents them in order to decode. Handles decode
// stalls and redirects, squashing any fetch still in flight.
// Optional feature macro: IF_FIFO_BYPASS_EN -- when defined, a word acked
// while the queue is empty is forwarded combinationally to inst/inst_pc in
// the ack cycle (0-cycle fetch latency); when undefined, the ack edge pushes
// the word and it appears one cycle later.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   imem_req/imem_addr          registered fetch request, held until acked
//   imem_ack/imem_rdata         request completion and returned word
//   redirect_valid/redirect_pc  flush and restart fetch at redirect_pc
//   stall                       decode not accepting this cycle
//   inst_valid/inst/inst_pc     head of queue to IF/ID (NOP / 0 when empty)
// -----------------------------------------------------------------------------
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  fetch_state_e  state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   imem_addr_q;
  logic          imem_req_q;

  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          ack_req;
  logic          bypass_fire;
  logic          push;
  logic          head_pop;
  logic [31:0]   redir_pc;

  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign ack_req  = (state_q == REQ) && imem_ack;

`ifdef IF_FIFO_BYPASS_EN
  assign bypass_fire = ack_req && !redirect_valid && (count == '0);
`else
  assign bypass_fire = 1'b0;
`endif

  // A forwarded word that decode takes this cycle never enters the queue.
  assign push     = ack_req && !redirect_valid && !(bypass_fire && !stall);
  assign head_pop = (count != '0) && !stall && !redirect_valid;

  // Occupancy after this edge; decides whether the next request may follow
  // back-to-back without risking a push into a full queue.
  assign count_after = count + CW'(push) - CW'(head_pop);

  assign push_entry = '{pc: imem_addr_q, inst: imem_rdata};

  if_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (head_pop),
    .flush_i     (redirect_valid),
    .push_data_i (push_entry),
    .count_o     (count),
    .head_o      (head)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    inst_valid = 1'b0;
    inst       = NOP_INST;
    inst_pc    = 32'h0;
    if (count != '0) begin
      inst_valid = 1'b1;
      inst       = head.inst;
      inst_pc    = head.pc;
    end
`ifdef IF_FIFO_BYPASS_EN
    else if (bypass_fire) begin
      inst_valid = 1'b1;
      inst       = imem_rdata;
      inst_pc    = imem_addr_q;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_addr_q <= RESET_PC;
      imem_req_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect_valid) begin
            // Queue is flushed on this edge, so credit is guaranteed.
            fetch_pc_q  <= redir_pc;
            imem_addr_q <= redir_pc;
            imem_req_q  <= 1'b1;
            state_q     <= REQ;
          end else if (count < DEPTH_C) begin
            imem_addr_q <= fetch_pc_q;
            imem_req_q  <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            fetch_pc_q <= redir_pc;
            if (imem_ack) begin
              imem_req_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              // Request cannot be withdrawn; keep the address stable.
              state_q <= DROP;
            end
          end else if (imem_ack) begin
            fetch_pc_q <= imem_addr_q + 32'd4;
            if (count_after < DEPTH_C) begin
              imem_addr_q <= imem_addr_q + 32'd4;
            end else begin
              imem_req_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        DROP: begin
          if (redirect_valid) fetch_pc_q <= redir_pc;
          if (imem_ack) begin
            imem_req_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          imem_req_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed, table-driven bench for if_fetch_unit (DEPTH=4, RESET_PC=0).
// Each table row is driven on a falling edge and the outputs are compared
// 1 time unit later, before the next rising edge. Instruction words are
// derived from their address with word_of() so every expected inst is known.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] ack_addr;
    logic        redir;
    logic [31:0] rpc;
    logic        stl;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int   n_vec;
  int   n_err;
  vec_t vecs[$];

  if_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // rst, ack, acked address, redirect, redirect pc, stall |
  // expected req, addr, inst_valid, inst_pc
  task automatic add(input logic r, input logic a, input logic [31:0] aa,
                     input logic rd, input logic [31:0] rp, input logic s,
                     input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.ack = a; v.ack_addr = aa; v.redir = rd; v.rpc = rp; v.stl = s;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    drive_idle();

`ifndef IF_FIFO_BYPASS_EN
    add(0,0,0,0,0,0, 0,32'h0,0,0);                 // reset values
    // zero-wait memory, no stall
    add(1,0,0,0,0,0, 0,32'h0,0,0);
    add(1,1,32'h0,0,0,0, 1,32'h0,0,0);
    add(1,1,32'h4,0,0,0, 1,32'h4,1,32'h0);
    add(1,1,32'h8,0,0,0, 1,32'h8,1,32'h4);
    add(1,1,32'hC,0,0,0, 1,32'hC,1,32'h8);
    add(1,0,0,0,0,0, 1,32'h10,1,32'hC);
    add(0,0,0,0,0,0, 0,32'h0,0,0);                 // reset pulse
    // stall held: four acks fill the queue, then req drops
    add(1,0,0,0,0,1, 0,32'h0,0,0);
    add(1,1,32'h0,0,0,1, 1,32'h0,0,0);
    add(1,1,32'h4,0,0,1, 1,32'h4,1,32'h0);
    add(1,1,32'h8,0,0,1, 1,32'h8,1,32'h0);
    add(1,1,32'hC,0,0,1, 1,32'hC,1,32'h0);
    add(1,0,0,0,0,1, 0,32'h0,1,32'h0);
    add(1,0,0,0,0,1, 0,32'h0,1,32'h0);
    add(1,0,0,0,0,0, 0,32'h0,1,32'h0);             // stall released
    add(1,0,0,0,0,0, 0,32'h0,1,32'h4);
    add(1,0,0,0,0,0, 1,32'h10,1,32'h8);            // fetch resumes at 0x10
    add(1,1,32'h10,0,0,0, 1,32'h10,1,32'hC);
    add(1,0,0,0,0,0, 1,32'h14,1,32'h10);
    // 3-cycle ack, redirect in the 2nd wait cycle -> DROP
    add(1,0,0,1,32'h100,0, 1,32'h14,0,0);
    add(1,0,0,0,0,0, 1,32'h14,0,0);
    add(1,1,32'h14,0,0,0, 1,32'h14,0,0);           // squashed word
    add(1,0,0,0,0,0, 0,32'h0,0,0);
    add(1,1,32'h100,0,0,0, 1,32'h100,0,0);
    add(1,0,0,0,0,0, 1,32'h104,1,32'h100);
    // redirect in the ack cycle
    add(1,1,32'h104,1,32'h200,0, 1,32'h104,0,0);
    add(1,0,0,0,0,0, 0,32'h0,0,0);
    add(1,1,32'h200,0,0,0, 1,32'h200,0,0);
    add(1,1,32'h204,0,0,1, 1,32'h204,1,32'h200);
    // redirect with two entries queued, then again while in DROP
    add(1,0,0,1,32'h300,0, 1,32'h208,1,32'h200);
    add(1,0,0,0,0,0, 1,32'h208,0,0);
    add(1,0,0,1,32'hFFFF_FFFE,0, 1,32'h208,0,0);
    add(1,1,32'h208,0,0,0, 1,32'h208,0,0);
    add(1,0,0,0,0,0, 0,32'h0,0,0);
    add(1,1,32'hFFFF_FFFC,0,0,0, 1,32'hFFFF_FFFC,0,0);
    add(1,0,0,0,0,0, 1,32'h0,1,32'hFFFF_FFFC);     // PC wrapped to 0
    // reset mid-request with two entries queued
    add(1,1,32'h0,0,0,1, 1,32'h0,0,0);
    add(1,1,32'h4,0,0,1, 1,32'h4,1,32'h0);
    add(1,0,0,0,0,1, 1,32'h8,1,32'h0);
    add(0,0,0,0,0,1, 0,32'h0,0,0);
    add(1,0,0,0,0,0, 0,32'h0,0,0);
    add(1,0,0,0,0,0, 1,32'h0,0,0);
`else
    add(0,0,0,0,0,0, 0,32'h0,0,0);
    add(1,0,0,0,0,0, 0,32'h0,0,0);
    add(1,1,32'h0,0,0,0, 1,32'h0,1,32'h0);         // forwarded, consumed
    add(1,1,32'h4,0,0,0, 1,32'h4,1,32'h4);
    add(1,1,32'h8,0,0,1, 1,32'h8,1,32'h8);         // forwarded, stalled -> pushed
    add(1,1,32'hC,0,0,0, 1,32'hC,1,32'h8);
    add(1,0,0,0,0,0, 1,32'h10,1,32'hC);
    add(1,1,32'h10,1,32'h80,0, 1,32'h10,0,0);      // no forwarding under redirect
    add(1,0,0,0,0,0, 0,32'h0,0,0);
    add(1,0,0,0,0,0, 1,32'h80,0,0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      imem_ack       = vecs[i].ack;
      imem_rdata     = vecs[i].ack ? word_of(vecs[i].ack_addr) : 32'h0;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      stall          = vecs[i].stl;
      #1;
      check($sformatf("v%0d.req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req || !vecs[i].rst)
        check($sformatf("v%0d.addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d.valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d.inst", i), inst,
            vecs[i].e_valid ? word_of(vecs[i].e_pc) : 32'h0);
      check($sformatf("v%0d.pc", i), inst_pc, vecs[i].e_valid ? vecs[i].e_pc : 32'h0);
    end

    // Sequence: fill the queue under stall, redirect from IDLE, then fetch
    // with a 2-cycle memory and confirm in-order delivery from the target.
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      imem_ack   = 1'b1;
      imem_rdata = word_of(32'(k * 4));
      @(negedge clk);
    end
    imem_ack = 1'b0;
    #1;
    check("fill.req_low", {31'b0, imem_req}, 32'h0);
    check("fill.full_head", inst_pc, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    stall          = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("idle_redir.req", {31'b0, imem_req}, 32'h1);
    check("idle_redir.addr", imem_addr, 32'h40);
    check("idle_redir.valid", {31'b0, inst_valid}, 32'h0);

    begin
      int          got = 0;
      int          wait_c = 0;
      logic [31:0] exp_pc = 32'h40;
      for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
        if (cyc != 0) @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        if (imem_req) begin
          if (wait_c == 2) begin
            imem_ack   = 1'b1;
            imem_rdata = word_of(imem_addr);
            wait_c     = 0;
          end else begin
            wait_c++;
          end
        end
        #1;
        if (inst_valid) begin
          check($sformatf("seq.pc%0d", got), inst_pc, exp_pc);
          check($sformatf("seq.inst%0d", got), inst, word_of(exp_pc));
          exp_pc += 32'd4;
          got++;
        end
      end
      check("seq.delivered", 32'(got), 32'd3);
    end

    @(negedge clk);
    drive_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
